// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared constants for the CP0 block: register numbers,
//                exception codes, SR/Cause field positions, PRId value and
//                field packing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] C_REG_SR    = 5'd12;
    localparam logic [4:0] C_REG_CAUSE = 5'd13;
    localparam logic [4:0] C_REG_EPC   = 5'd14;
    localparam logic [4:0] C_REG_PRID  = 5'd15;

    // Exception codes
    localparam logic [4:0] C_EXC_INT  = 5'd0;
    localparam logic [4:0] C_EXC_ADEL = 5'd4;
    localparam logic [4:0] C_EXC_ADES = 5'd5;
    localparam logic [4:0] C_EXC_RI   = 5'd10;
    localparam logic [4:0] C_EXC_OV   = 5'd12;

    // SR field positions
    localparam int C_SR_IE_BIT  = 0;
    localparam int C_SR_EXL_BIT = 1;
    localparam int C_SR_IM_LO   = 10;
    localparam int C_SR_IM_HI   = 15;

    // Cause field positions
    localparam int C_CAUSE_EXC_LO = 2;
    localparam int C_CAUSE_EXC_HI = 6;
    localparam int C_CAUSE_IP_LO  = 10;
    localparam int C_CAUSE_IP_HI  = 15;
    localparam int C_CAUSE_BD_BIT = 31;

    // Processor identification
    localparam logic [31:0] C_PRID_VALUE = 32'h4255_4141;

    // Assemble the architectural SR view; unused bits read as zero
    function automatic logic [31:0] sr_pack(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v = '0;
        v[C_SR_IM_HI:C_SR_IM_LO] = im;
        v[C_SR_EXL_BIT]          = exl;
        v[C_SR_IE_BIT]           = ie;
        return v;
    endfunction

    // Assemble the architectural Cause view; unused bits read as zero
    function automatic logic [31:0] cause_pack(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[C_CAUSE_BD_BIT]                = bd;
        v[C_CAUSE_IP_HI:C_CAUSE_IP_LO]   = ip;
        v[C_CAUSE_EXC_HI:C_CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_exc_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_arb
//  Description : Combinational exception/interrupt arbiter. Decides whether
//                the commit-stage instruction must be redirected to the
//                handler and which ExcCode gets recorded. Interrupts win.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] sr_im,
    input  logic       sr_ie,
    input  logic       sr_exl,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] exc_code
);

    // EXL masks everything: nested exceptions are not supported
    always_comb begin
        int_req  = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req  = (exc_code_in != C_EXC_INT) & ~sr_exl;
        req      = int_req | exc_req;
        exc_code = int_req ? C_EXC_INT : exc_code_in;
    end

endmodule
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
//  Module      : cp0
//  Description : MIPS-style coprocessor 0 subset: SR, Cause, EPC and PRId,
//                with mtc0/mfc0 access, exception/interrupt entry and eret.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] epc_out,
    output logic        req
);

    // Architectural state, held as individual fields
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [4:0]  w_exc_code;
    logic        w_sr_wr;
    logic        w_epc_wr;

    cp0_exc_arb u_arb (
        .hw_int      (hw_int),
        .sr_im       (r_sr_im),
        .sr_ie       (r_sr_ie),
        .sr_exl      (r_sr_exl),
        .exc_code_in (exc_code_in),
        .int_req     (w_int_req),
        .exc_req     (w_exc_req),
        .req         (w_req),
        .exc_code    (w_exc_code)
    );

    // The handler redirect is a pure function of current state and inputs
    assign req     = w_req;
    assign epc_out = r_epc;

    // mtc0 decode; only SR and EPC are software-writable
    assign w_sr_wr  = en && (cp0_addr == C_REG_SR);
    assign w_epc_wr = en && (cp0_addr == C_REG_EPC);

    // Sanity check that the arbiter's request matches its two sources
    always_comb begin : p_arb_consistency
        assert (w_req == (w_int_req | w_exc_req));
    end

    // Register update: reset, then exception entry, then mtc0/eret
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            // Pending lines are sampled every cycle regardless of activity
            r_cause_ip <= hw_int;
            if (w_req) begin
                // Entry suppresses any concurrent mtc0 and keeps EXL set
                // even if an eret commits in the same cycle
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bd_in;
                r_cause_exc <= w_exc_code;
                r_epc       <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (w_sr_wr) begin
                    r_sr_im <= cp0_in[C_SR_IM_HI:C_SR_IM_LO];
                    r_sr_ie <= cp0_in[C_SR_IE_BIT];
                end
                // eret overrides an SR write of the EXL bit
                if (exl_clr) begin
                    r_sr_exl <= 1'b0;
                end else if (w_sr_wr) begin
                    r_sr_exl <= cp0_in[C_SR_EXL_BIT];
                end
                if (w_epc_wr) begin
                    r_epc <= cp0_in;
                end
            end
        end
    end

    // mfc0 read mux; unimplemented numbers read zero
    always_comb begin
        cp0_out = 32'h0;
        case (cp0_addr)
            C_REG_SR:    cp0_out = sr_pack(r_sr_im, r_sr_exl, r_sr_ie);
            C_REG_CAUSE: cp0_out = cause_pack(r_cause_bd, r_cause_ip, r_cause_exc);
            C_REG_EPC:   cp0_out = r_epc;
            C_REG_PRID:  cp0_out = C_PRID_VALUE;
            default:     cp0_out = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0
//  Description : Self-checking bench for cp0. A reference model predicts the
//                register file after every cycle; predictions are queued when
//                stimulus is applied and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    cp0 u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_in      (cp0_in),
        .cp0_out     (cp0_out),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .exl_clr     (exl_clr),
        .epc_out     (epc_out),
        .req         (req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [5:0]  addr;   // 32 selects epc_out instead of an mfc0 read
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    // Reference model state
    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic [5:0]  m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_out, exp);
    endtask

    // One clock cycle: drive, predict, enqueue expectations, clock, compare
    task automatic step(input string tag, input bit rst, input bit we,
                        input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] pc, input bit bd,
                        input logic [4:0] ec, input logic [5:0] hw, input bit clr);
        bit        m_int;
        bit        m_exc;
        bit        m_req;
        sb_entry_t e;
        @(negedge clk);
        reset = rst; en = we; cp0_addr = a; cp0_in = d; vpc = pc;
        bd_in = bd; exc_code_in = ec; hw_int = hw; exl_clr = clr;
        #1;
        m_int = (|(hw & m_im)) && m_ie && !m_exl;
        m_exc = (ec != 5'd0) && !m_exl;
        m_req = m_int || m_exc;
        if (!rst) check({tag, ".req"}, {31'b0, req}, {31'b0, m_req});
        if (rst) begin
            m_im = '0; m_exl = 1'b0; m_ie = 1'b0;
            m_bd = 1'b0; m_ip = '0; m_code = '0; m_epc = '0;
        end else begin
            m_ip = hw;
            if (m_req) begin
                m_exl  = 1'b1;
                m_bd   = bd;
                m_code = m_int ? 5'd0 : ec;
                m_epc  = bd ? pc - 32'd4 : pc;
            end else begin
                if (we && a == 5'd12) begin
                    m_im = d[15:10]; m_exl = d[1]; m_ie = d[0];
                end
                if (we && a == 5'd14) m_epc = d;
                if (clr) m_exl = 1'b0;
            end
        end
        sb.push_back('{{tag, ".sr"},    6'd12, {16'b0, m_im, 8'b0, m_exl, m_ie}});
        sb.push_back('{{tag, ".cause"}, 6'd13, {m_bd, 15'b0, m_ip, 3'b0, m_code, 2'b0}});
        sb.push_back('{{tag, ".epc"},   6'd14, m_epc});
        sb.push_back('{{tag, ".prid"},  6'd15, 32'h4255_4141});
        sb.push_back('{{tag, ".unimp"}, 6'd3,  32'h0});
        sb.push_back('{{tag, ".epcout"},6'd32, m_epc});
        @(posedge clk);
        #1;
        en = 1'b0; exl_clr = 1'b0; exc_code_in = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.addr == 6'd32) begin
                check(e.tag, epc_out, e.exp);
            end else begin
                cp0_addr = e.addr[4:0];
                #1;
                check(e.tag, cp0_out, e.exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cp0_addr = '0; cp0_in = '0; vpc = '0;
        bd_in = 1'b0; exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
        m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
        m_ip = '0; m_code = '0; m_epc = '0;

        // Reset wins over en/req/exl_clr
        step("rst0", 1, 1, 5'd12, 32'hFFFF_FFFF, 32'h10, 1, 5'd12, 6'h3F, 1);
        step("rst1", 1, 1, 5'd14, 32'h1234_5678, 32'h10, 1, 5'd12, 6'h3F, 1);

        // Enable all interrupts, then raise line 2
        step("sr_wr", 0, 1, 5'd12, 32'h0000_FC01, 32'h100, 0, 5'd0, 6'b000000, 0);
        step("irq2",  0, 0, 5'd0,  32'h0,         32'h104, 0, 5'd0, 6'b000100, 0);
        peek("irq2.cause_abs", 5'd13, 32'h0000_1000);

        // EXL masks a synchronous exception; eret clears EXL, EPC unchanged
        step("exl_mask", 0, 0, 5'd0, 32'h0, 32'h108, 0, 5'd4, 6'b000000, 0);
        step("eret",     0, 0, 5'd0, 32'h0, 32'h10C, 0, 5'd0, 6'b000000, 1);
        peek("eret.epc_abs", 5'd14, 32'h0000_0104);

        // IE=0: lines pending but no request
        step("ie_off", 0, 1, 5'd12, 32'h0000_FC00, 32'h110, 0, 5'd0, 6'b000000, 0);
        step("ip_all", 0, 0, 5'd0,  32'h0,         32'h114, 0, 5'd0, 6'b111111, 0);
        peek("ip_all.cause_abs", 5'd13, 32'h0000_FC00);

        // Overflow in a delay slot
        step("ov_bd", 0, 0, 5'd0, 32'h0, 32'h0000_3010, 1, 5'd12, 6'b000000, 0);
        peek("ov_bd.epc_abs",   5'd14, 32'h0000_300C);
        peek("ov_bd.cause_abs", 5'd13, 32'h8000_0030);

        // eret and SR write on the same edge: eret wins on EXL
        step("eret_sr", 0, 1, 5'd12, 32'h0000_FC03, 32'h200, 0, 5'd0, 6'b000000, 1);

        // RI with an enabled interrupt: interrupt wins
        step("ri_irq", 0, 0, 5'd0, 32'h0, 32'h0000_2000, 0, 5'd10, 6'b000001, 0);
        step("eret2",  0, 0, 5'd0, 32'h0, 32'h2004, 0, 5'd0, 6'b000000, 1);

        // Request on the same edge as eret keeps EXL set
        step("req_eret", 0, 0, 5'd0, 32'h0, 32'h3000, 1, 5'd0, 6'b000001, 1);
        step("eret3",    0, 0, 5'd0, 32'h0, 32'h3004, 0, 5'd0, 6'b000000, 1);

        // mtc0 EPC suppressed by a concurrent exception
        step("epc_supp", 0, 1, 5'd14, 32'h0000_4000, 32'h0000_5000, 0, 5'd5, 6'b000000, 0);
        peek("epc_supp.epc_abs", 5'd14, 32'h0000_5000);

        // Writes to PRId and Cause are ignored; plain EPC write lands
        step("prid_wr",  0, 1, 5'd15, 32'h0,         32'h0, 0, 5'd0, 6'b000000, 0);
        step("cause_wr", 0, 1, 5'd13, 32'hFFFF_FFFF, 32'h0, 0, 5'd0, 6'b000000, 0);
        step("epc_wr",   0, 1, 5'd14, 32'h0000_4000, 32'h0, 0, 5'd0, 6'b000000, 0);
        peek("epc_wr.epc_abs", 5'd14, 32'h0000_4000);

        // Reset mid-handler clears EXL; no interrupt until IE is set again
        step("rst_mid", 1, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 6'b111111, 0);
        step("post_rst", 0, 0, 5'd0, 32'h0, 32'h600, 0, 5'd0, 6'b111111, 0);
        step("ie_on",    0, 1, 5'd12, 32'h0000_FC01, 32'h604, 0, 5'd0, 6'b000000, 0);
        step("irq5",     0, 0, 5'd0, 32'h0, 32'h608, 0, 5'd0, 6'b100000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL provide port en, input, 1 bit: mtc0 write enable.
REQ-004 The block SHALL provide port cp0_addr, input, 5 bits: register number for mtc0/mfc0.
REQ-005 The block SHALL provide port cp0_in, input, 32 bits: mtc0 write data.
REQ-006 The block SHALL provide port cp0_out, output, 32 bits: mfc0 read data.
REQ-007 The block SHALL provide port vpc, input, 32 bits: PC of the victim instruction at the commit stage.
REQ-008 The block SHALL provide port bd_in, input, 1 bit: the victim instruction is in a branch delay slot.
REQ-009 The block SHALL provide port exc_code_in, input, 5 bits: synchronous exception code, where 0 means none.
REQ-010 The block SHALL provide port hw_int, input, 6 bits: external interrupt lines; bit 0 maps to IP[10].
REQ-011 The block SHALL provide port exl_clr, input, 1 bit: eret commit.
REQ-012 The block SHALL provide port epc_out, output, 32 bits: current EPC, used as the eret target.
REQ-013 The block SHALL provide port req, output, 1 bit: take exception/interrupt this cycle, driving the PC-register redirect to the handler.

Function
REQ-014 Registers:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits SHALL read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits SHALL read 0.
- EPC (14): 32 bits.
- PRId (15): constant 32'h4255_4141.
REQ-015 cp0_out SHALL be combinational from cp0_addr; unimplemented addresses SHALL read 32'h0.
REQ-016 int_req SHALL be |(hw_int & SR.IM) & SR.IE & ~SR.EXL, computed from the current register values and the current hw_int.
REQ-017 exc_req SHALL be (exc_code_in != 0) & ~SR.EXL.
REQ-018 req SHALL equal int_req | exc_req, combinationally, with zero latency.
REQ-019 When both int_req and exc_req are set, the interrupt SHALL win and ExcCode SHALL be 0.
REQ-020 On a clock edge with req=1:
- EXL SHALL be set to 1.
- Cause.BD SHALL take bd_in.
- ExcCode SHALL take 0 for an interrupt, else exc_code_in.
- EPC SHALL take vpc-4 when bd_in=1, else vpc.
REQ-021 Cause.IP SHALL be reloaded from hw_int on every non-reset edge, independent of req or en.
REQ-022 mtc0 (en=1) SHALL write SR (IM, EXL and IE fields only) or EPC (all 32 bits) on the next edge.
REQ-023 mtc0 writes to Cause, PRId or any other address SHALL be ignored.
REQ-024 When req=1 on the same edge as en=1, the mtc0 write SHALL be suppressed entirely.
REQ-025 exl_clr=1 SHALL clear EXL on the next edge, unless req=1 on the same edge, in which case EXL SHALL stay 1.
REQ-026 When exl_clr and a mtc0 write to SR occur on the same edge, exl_clr SHALL override the written EXL bit.
REQ-027 epc_out SHALL be the registered EPC value, updated one cycle after the write.
REQ-028 While EXL=1, req SHALL be 0 regardless of hw_int or exc_code_in; nested exceptions are not supported.

Reset
REQ-029 On a reset edge, SR, Cause and EPC SHALL be cleared to 0.
REQ-030 Reset SHALL take priority over req, en and exl_clr.
REQ-031 During reset, req SHALL be computed from the cleared registers, so req=0 from the first post-reset cycle.
REQ-032 PRId SHALL be unaffected by reset.
REQ-033 A mid-handler reset SHALL clear EXL, so the next interrupt is taken only after software sets IE.

Structure
REQ-034 A shared package cp0_pkg SHALL hold:
- register numbers: SR=12, CAUSE=13, EPC=14, PRID=15;
- ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
- SR/Cause field bit positions;
- the PRId value.
REQ-035 A single combinational sub-module cp0_exc_arb SHALL compute int_req, exc_req, req and the selected ExcCode; all state SHALL live in cp0.

Verification
REQ-036 Scenario: reset, then SR=32'h0000_FC01 via mtc0, then hw_int=6'b000100 -> req=1 the same cycle; next cycle Cause=32'h0000_1000 and EXL=1.
REQ-037 Scenario: SR.IE=0 with hw_int=6'b111111 -> req=0; Cause.IP=6'b111111 is visible via mfc0 13.
REQ-038 Scenario: exc_code_in=12, vpc=32'h0000_3010, bd_in=1 -> req=1; afterwards EPC=32'h0000_300C and Cause=32'h8000_0030.
REQ-039 Scenario: exc_code_in=10 with an enabled hw_int in the same cycle -> ExcCode=0 (interrupt wins) and EPC=vpc.
REQ-040 Scenario: EXL=1 with exc_code_in=4 -> req=0; then exl_clr=1 -> EXL=0 and epc_out is unchanged.
REQ-041 Scenario: en=1 writing EPC=32'h0000_4000 in the same cycle as req=1 -> EPC=vpc (write suppressed); mtc0 to address 15 -> PRId still reads 32'h4255_4141.
